// File: rtl/hslp_mac_acc_pkg.sv
// Shared definitions for the hslp_mac_acc accumulation stage:
// the FSM state type and the product width of the upstream multiplier.
package hslp_pkg;

  localparam int HSLP_PROD_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DONE
  } hslp_acc_state_t;

endpackage

// File: rtl/hslp_mac_acc_if.sv
// Handshake bundle for hslp_mac_acc: job control, product input stream
// and result output stream. The master side is the job issuer/consumer.
interface hslp_mac_acc_if #(
  parameter int ACC_W = 24,
  parameter int LEN_W = 8
);
  import hslp_pkg::*;

  logic                   start;
  logic [LEN_W-1:0]       len;
  logic                   busy;
  logic                   in_valid;
  logic                   in_ready;
  logic [HSLP_PROD_W-1:0] prod;
  logic                   out_valid;
  logic                   out_ready;
  logic [ACC_W-1:0]       acc_out;
  logic                   ovf;

  modport master (
    output start, len, in_valid, prod, out_ready,
    input  busy, in_ready, out_valid, acc_out, ovf
  );

  modport slave (
    input  start, len, in_valid, prod, out_ready,
    output busy, in_ready, out_valid, acc_out, ovf
  );

endinterface

// File: rtl/hslp_mac_acc_add.sv
// Combinational ACC_W-wide adder of accumulator plus zero-extended product.
// Carry-out flags overflow. Build option HSLP_ACC_SATURATE_EN clamps the sum
// to all-ones on carry-out; otherwise the sum wraps modulo 2^ACC_W.
module hslp_acc_add
  import hslp_pkg::*;
#(
  parameter int ACC_W = 24
) (
  input  logic [ACC_W-1:0]       acc_i,
  input  logic [HSLP_PROD_W-1:0] prod_i,
  output logic [ACC_W-1:0]       sum_o,
  output logic                   carry_o
);

  logic [ACC_W:0] wide_sum;

  // One extra bit of headroom captures the carry-out of the add.
  always_comb begin
    wide_sum = {1'b0, acc_i} + {{(ACC_W + 1 - HSLP_PROD_W){1'b0}}, prod_i};
    carry_o  = wide_sum[ACC_W];
`ifdef HSLP_ACC_SATURATE_EN
    sum_o    = carry_o ? {ACC_W{1'b1}} : wide_sum[ACC_W-1:0];
`else
    sum_o    = wide_sum[ACC_W-1:0];
`endif
  end

endmodule

// File: rtl/hslp_mac_acc.sv
// hslp_mac_acc: sums a programmed number of 16-bit products into an ACC_W
// accumulator and returns one result per job with a sticky overflow flag.
// Build option: HSLP_ACC_SATURATE_EN selects saturating (vs wrapping) adds.
module hslp_mac_acc
  import hslp_pkg::*;
#(
  parameter int ACC_W = 24,
  parameter int LEN_W = 8
) (
  input logic           clk,
  input logic           rst,
  hslp_mac_acc_if.slave bus
);

  if (ACC_W < HSLP_PROD_W) begin : g_bad_acc_w
    $error("hslp_mac_acc: ACC_W must be at least the product width");
  end

  hslp_acc_state_t  state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;

  logic [ACC_W-1:0] sum;
  logic             carry;

  hslp_acc_add #(.ACC_W(ACC_W)) u_add (
    .acc_i   (acc_q),
    .prod_i  (bus.prod),
    .sum_o   (sum),
    .carry_o (carry)
  );

  // State and datapath registers with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state and datapath update: capture a job, accumulate beats, hand off.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a value unassigned and no latch is inferred.
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          len_d   = bus.len;
          cnt_d   = '0;
          acc_d   = '0;
          ovf_d   = 1'b0;
          state_d = (bus.len == '0) ? DONE : ACC;
        end
      end
      ACC: begin
        if (bus.in_valid) begin
          acc_d = sum;
          cnt_d = cnt_q + LEN_W'(1);
          ovf_d = ovf_q | carry;
          if (cnt_q == len_q - LEN_W'(1)) state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.in_ready  = (state_q == ACC);
  assign bus.out_valid = (state_q == DONE);
  assign bus.acc_out   = acc_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_hslp_mac_acc.sv
// Directed self-checking bench for hslp_mac_acc (ACC_W=24, LEN_W=9 so that
// the 257-product overflow job fits in the length field).
module tb_hslp_mac_acc;

  localparam int ACC_W = 24;
  localparam int LEN_W = 9;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  hslp_mac_acc_if #(.ACC_W(ACC_W), .LEN_W(LEN_W)) bus ();

  hslp_mac_acc #(.ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0d (0x%0h) expected=%0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Called at a negedge; start is sampled on the following posedge.
  task automatic start_job(input logic [LEN_W-1:0] l);
    bus.start = 1'b1;
    bus.len   = l;
    @(negedge clk);
    bus.start = 1'b0;
    bus.len   = '1;
  endtask

  // Offer one product, wait (bounded) until it is accepted, then idle 'gap' cycles.
  task automatic feed(input logic [15:0] p, input int gap);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.prod     = p;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("feed_timeout", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.prod     = 16'hDEAD;
    repeat (gap) @(negedge clk);
  endtask

  // Expect a pending result, take it, and confirm the return to IDLE.
  task automatic finish_job(input string tag, input logic [31:0] exp_acc, input logic exp_ovf);
    check({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'd1);
    check({tag, "_acc"}, {8'd0, bus.acc_out}, exp_acc);
    check({tag, "_ovf"}, {31'd0, bus.ovf}, {31'd0, exp_ovf});
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, "_valid_drop"}, {31'd0, bus.out_valid}, 32'd0);
    check({tag, "_idle"}, {31'd0, bus.busy}, 32'd0);
    check({tag, "_acc_held"}, {8'd0, bus.acc_out}, exp_acc);
  endtask

  initial begin
    longint          big_sum;
    logic [ACC_W-1:0] exp_ovf_acc;
    checks        = 0;
    failures      = 0;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.len       = '0;
    bus.in_valid  = 1'b0;
    bus.prod      = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state.
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_acc", {8'd0, bus.acc_out}, 32'd0);
    check("rst_ovf", {31'd0, bus.ovf}, 32'd0);

    // Normal job: 100+200+300+400 = 1000.
    start_job(9'd4);
    check("norm_in_ready_lat", {31'd0, bus.in_ready}, 32'd1);
    check("norm_busy", {31'd0, bus.busy}, 32'd1);
    feed(16'd100, 0);
    feed(16'd200, 0);
    feed(16'd300, 0);
    feed(16'd400, 0);
    finish_job("norm", 32'd1000, 1'b0);

    // Stalls on both sides: 7+0+65535 = 65542, consumer holds off 5 cycles.
    start_job(9'd3);
    feed(16'd7, 2);
    feed(16'd0, 2);
    feed(16'd65535, 0);
    for (int i = 0; i < 5; i++) begin
      check("stall_valid_hold", {31'd0, bus.out_valid}, 32'd1);
      check("stall_acc_hold", {8'd0, bus.acc_out}, 32'd65542);
      check("stall_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
      @(negedge clk);
    end
    finish_job("stall", 32'd65542, 1'b0);

    // Empty job with in_valid held high and out_ready already high:
    // result the cycle after start, valid for exactly one cycle.
    bus.in_valid  = 1'b1;
    bus.prod      = 16'd55;
    bus.out_ready = 1'b1;
    start_job(9'd0);
    check("empty_out_valid", {31'd0, bus.out_valid}, 32'd1);
    check("empty_acc", {8'd0, bus.acc_out}, 32'd0);
    check("empty_in_ready", {31'd0, bus.in_ready}, 32'd0);
    @(negedge clk);
    check("empty_one_cycle", {31'd0, bus.out_valid}, 32'd0);
    check("empty_acc_after", {8'd0, bus.acc_out}, 32'd0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;

    // Overflow: 257 x 65535 = 16842495 exceeds 2^24 - 1.
    big_sum = 64'd257 * 64'd65535;
`ifdef HSLP_ACC_SATURATE_EN
    exp_ovf_acc = {ACC_W{1'b1}};
`else
    exp_ovf_acc = big_sum[ACC_W-1:0];
`endif
    start_job(9'd257);
    for (int i = 0; i < 257; i++) feed(16'hFFFF, 0);
    finish_job("ovf257", {8'd0, exp_ovf_acc}, 1'b1);

    // Boundary just below overflow: 256 x 65535 = 16776960, ovf cleared by start.
    start_job(9'd256);
    for (int i = 0; i < 256; i++) feed(16'hFFFF, 0);
    finish_job("ovf256", 32'd16776960, 1'b0);

    // Reset mid-job after 2 of 4 beats, then a fresh job 5+6 = 11.
    start_job(9'd4);
    feed(16'd10, 0);
    feed(16'd20, 0);
    check("midrst_pre_busy", {31'd0, bus.busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", {31'd0, bus.busy}, 32'd0);
    check("midrst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("midrst_acc", {8'd0, bus.acc_out}, 32'd0);
    check("midrst_ovf", {31'd0, bus.ovf}, 32'd0);
    start_job(9'd2);
    feed(16'd5, 0);
    feed(16'd6, 0);
    finish_job("restart", 32'd11, 1'b0);

    // start with a different len during ACC is ignored: job stays 3 beats.
    start_job(9'd3);
    feed(16'd1, 0);
    bus.start = 1'b1;
    bus.len   = 9'd1;
    @(negedge clk);
    bus.start = 1'b0;
    check("ign_still_busy", {31'd0, bus.in_ready}, 32'd1);
    feed(16'd2, 0);
    check("ign_not_done", {31'd0, bus.out_valid}, 32'd0);
    feed(16'd3, 0);
    finish_job("ign", 32'd6, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
